// File: rtl/wb_stage_reg.sv
// Pipeline boundary register carrying write-back payload between two adjacent
// stages, with flush, bubble insertion, multi-cycle HI/LO carry-through and a stall counter.
module wb_stage_reg #(
    parameter int STAGE    = 4,
    parameter int CHANNELS = 1,
    parameter int CNT_W    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [5:0]              stall,
    input  logic                    flush,
    input  logic [5*CHANNELS-1:0]   in_wd,
    input  logic [CHANNELS-1:0]     in_wreg,
    input  logic [32*CHANNELS-1:0]  in_wdata,
    input  logic [31:0]             in_hi,
    input  logic [31:0]             in_lo,
    input  logic                    in_whilo,
    input  logic [63:0]             in_hilo_temp,
    input  logic [1:0]              in_cnt,
    output logic [5*CHANNELS-1:0]   out_wd,
    output logic [CHANNELS-1:0]     out_wreg,
    output logic [32*CHANNELS-1:0]  out_wdata,
    output logic [31:0]             out_hi,
    output logic [31:0]             out_lo,
    output logic                    out_whilo,
    output logic [63:0]             out_hilo_temp,
    output logic [1:0]              out_cnt,
    output logic                    out_valid,
    output logic [CNT_W-1:0]        stall_cnt
);

    logic up_stall;
    logic down_stall;
    logic clear;

    // Downstream-stalled with upstream running is never produced; it falls into advance.
    assign up_stall   = stall[STAGE];
    assign down_stall = stall[STAGE+1];
    assign clear      = rst || flush;

    always_ff @(posedge clk) begin
        if (clear) begin
            out_wd        <= '0;
            out_wreg      <= '0;
            out_wdata     <= '0;
            out_hi        <= '0;
            out_lo        <= '0;
            out_whilo     <= 1'b0;
            out_valid     <= 1'b0;
            out_hilo_temp <= '0;
            out_cnt       <= '0;
        end else if (up_stall && !down_stall) begin
            // Bubble goes downstream while the partial accumulate result survives the re-issue.
            out_wd        <= '0;
            out_wreg      <= '0;
            out_wdata     <= '0;
            out_hi        <= '0;
            out_lo        <= '0;
            out_whilo     <= 1'b0;
            out_valid     <= 1'b0;
            out_hilo_temp <= in_hilo_temp;
            out_cnt       <= in_cnt;
        end else if (!up_stall) begin
            out_wd        <= in_wd;
            out_wreg      <= in_wreg;
            out_wdata     <= in_wdata;
            out_hi        <= in_hi;
            out_lo        <= in_lo;
            out_whilo     <= in_whilo;
            out_valid     <= 1'b1;
            out_hilo_temp <= '0;
            out_cnt       <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (clear || !up_stall) begin
            stall_cnt <= '0;
        end else if (stall_cnt != {CNT_W{1'b1}}) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
